// File: rtl/alu_issue_stage_if.sv
// rv32i_pkg: decoded instruction format and instruction enums shared by the
// issue stage, its interface and anything that consumes the issued entry.
//
// alu_issue_stage_if: bundles the upstream (in_*) and downstream (out_*)
// handshakes of the ALU issue stage, plus the synchronous flush.
//   master modport : the environment (fetch/regfile side drives in_*,
//                    execute side drives out_ready, flush from control)
//   slave modport  : the issue stage itself
//
// Handshake rule, both sides: a transfer happens on a rising clk edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until that edge; ready never depends combinationally on valid.
package rv32i_pkg;

    typedef enum logic [2:0] {
        R_TYPE,
        I_TYPE,
        S_TYPE,
        B_TYPE,
        U_TYPE,
        J_TYPE
    } rv32i_base_instr_type;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } rv32i_base_instr;

endpackage

interface alu_issue_stage_if #(parameter int DATA_WIDTH = 32);
    import rv32i_pkg::*;

    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [31:0]            in_instr;
    logic [DATA_WIDTH-1:0]  in_pc;
    logic [DATA_WIDTH-1:0]  in_rs1_val;
    logic [DATA_WIDTH-1:0]  in_rs2_val;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_a;
    logic [DATA_WIDTH-1:0]  out_b;
    rv32i_base_instr_type   out_instr_type;
    rv32i_base_instr        out_opcode_e;
    logic [DATA_WIDTH-1:0]  out_imm;
    logic [DATA_WIDTH-1:0]  out_store_data;
    logic [DATA_WIDTH-1:0]  out_pc;
    logic [4:0]             out_rd;
    logic                   out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_instr_type, out_opcode_e,
               out_imm, out_store_data, out_pc, out_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, in_rs1_val, in_rs2_val, out_ready,
        output in_ready, out_valid, out_a, out_b, out_instr_type, out_opcode_e,
               out_imm, out_store_data, out_pc, out_rd, out_illegal
    );

endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I decode/issue stage producing ALU operands.
//
// Decodes a raw instruction word combinationally, and on each accepted input
// writes the decoded entry into a 2-entry FIFO (skid buffer). The head entry
// drives out_*. in_ready is registered and low only when both entries are held.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_issue_stage_if.slave: flush, in_* handshake/payload, out_*
//          handshake/decoded entry (a, b, type, opcode, imm, store data, pc,
//          rd, illegal)
//
// Illegal encodings still issue as an ADDI-shaped entry with zero operands and
// out_illegal set, so the trap is raised downstream in program order.
module alu_issue_stage
    import rv32i_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_issue_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] imm;
        logic [DATA_WIDTH-1:0] store_data;
        logic [DATA_WIDTH-1:0] pc;
        logic [4:0]            rd;
        rv32i_base_instr_type  instr_type;
        rv32i_base_instr       opcode_e;
        logic                  illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        a: '0, b: '0, imm: '0, store_data: '0, pc: '0, rd: '0,
        instr_type: I_TYPE, opcode_e: ADDI, illegal: 1'b0
    };

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    function automatic logic [DATA_WIDTH-1:0] sext32(input logic [31:0] v);
        return DATA_WIDTH'($signed(v));
    endfunction

    // ---------------------------------------------------------------- decode
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [DATA_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = sext32({{20{instr[31]}}, instr[31:20]});
    assign imm_s = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
    assign imm_b = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
    assign imm_u = sext32({instr[31:12], 12'b0});
    assign imm_j = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});
    assign shamt = DATA_WIDTH'(instr[24:20]);

    entry_t dec;
    logic   dec_illegal;

    always_comb begin
        dec            = RESET_ENTRY;
        dec.store_data = bus.in_rs2_val;
        dec.pc         = bus.in_pc;
        dec.rd         = instr[11:7];
        dec_illegal    = 1'b0;

        case (opcode)
            OP_REG: begin
                dec.instr_type = R_TYPE;
                dec.a          = bus.in_rs1_val;
                dec.b          = bus.in_rs2_val;
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0: dec.opcode_e = ADD;
                        3'd1: dec.opcode_e = SLL;
                        3'd2: dec.opcode_e = SLT;
                        3'd3: dec.opcode_e = SLTU;
                        3'd4: dec.opcode_e = XOR;
                        3'd5: dec.opcode_e = SRL;
                        3'd6: dec.opcode_e = OR;
                        default: dec.opcode_e = AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'd0) begin
                    dec.opcode_e = SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'd5) begin
                    dec.opcode_e = SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                dec.a   = bus.in_rs1_val;
                dec.b   = imm_i;
                dec.imm = imm_i;
                case (funct3)
                    3'd0: dec.opcode_e = ADDI;
                    3'd2: dec.opcode_e = SLTI;
                    3'd3: dec.opcode_e = SLTIU;
                    3'd4: dec.opcode_e = XORI;
                    3'd6: dec.opcode_e = ORI;
                    3'd7: dec.opcode_e = ANDI;
                    3'd1: begin
                        dec.opcode_e = SLLI;
                        dec.b        = shamt;
                        dec_illegal  = (funct7 != 7'h00);
                    end
                    default: begin
                        // funct3 = 5: instr[30] picks arithmetic shift
                        dec.opcode_e = instr[30] ? SRAI : SRLI;
                        dec.b        = shamt;
                        dec_illegal  = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            OP_LOAD: begin
                dec.a   = bus.in_rs1_val;
                dec.b   = imm_i;
                dec.imm = imm_i;
                case (funct3)
                    3'd0: dec.opcode_e = LB;
                    3'd1: dec.opcode_e = LH;
                    3'd2: dec.opcode_e = LW;
                    3'd4: dec.opcode_e = LBU;
                    3'd5: dec.opcode_e = LHU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_JALR: begin
                dec.opcode_e = JALR;
                dec.a        = bus.in_rs1_val;
                dec.b        = imm_i;
                dec.imm      = imm_i;
                dec_illegal  = (funct3 != 3'd0);
            end
            OP_STORE: begin
                dec.instr_type = S_TYPE;
                dec.a          = bus.in_rs1_val;
                dec.b          = imm_s;
                dec.imm        = imm_s;
                dec.rd         = '0;
                case (funct3)
                    3'd0: dec.opcode_e = SB;
                    3'd1: dec.opcode_e = SH;
                    3'd2: dec.opcode_e = SW;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                // Operands are the two registers; the ALU compares them by SUB
                // while the target offset travels separately on imm.
                dec.instr_type = B_TYPE;
                dec.a          = bus.in_rs1_val;
                dec.b          = bus.in_rs2_val;
                dec.imm        = imm_b;
                dec.rd         = '0;
                case (funct3)
                    3'd0: dec.opcode_e = BEQ;
                    3'd1: dec.opcode_e = BNE;
                    3'd4: dec.opcode_e = BLT;
                    3'd5: dec.opcode_e = BGE;
                    3'd6: dec.opcode_e = BLTU;
                    3'd7: dec.opcode_e = BGEU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_LUI: begin
                dec.instr_type = U_TYPE;
                dec.opcode_e   = LUI;
                dec.b          = imm_u;
                dec.imm        = imm_u;
            end
            OP_AUIPC: begin
                dec.instr_type = U_TYPE;
                dec.opcode_e   = AUIPC;
                dec.a          = bus.in_pc;
                dec.b          = imm_u;
                dec.imm        = imm_u;
            end
            OP_JAL: begin
                dec.instr_type = J_TYPE;
                dec.opcode_e   = JAL;
                dec.a          = bus.in_pc;
                dec.b          = imm_j;
                dec.imm        = imm_j;
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal) begin
            dec.instr_type = I_TYPE;
            dec.opcode_e   = ADDI;
            dec.a          = '0;
            dec.b          = '0;
            dec.imm        = '0;
            dec.rd         = '0;
            dec.illegal    = 1'b1;
        end
    end

    // ----------------------------------------------------------- skid buffer
    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic [1:0] count_next;
    logic       in_ready_q;
    logic       push;
    logic       pop;

    // Flush wins over both sides: the incoming word is dropped and the head
    // is not considered consumed.
    assign push = bus.in_valid && in_ready_q && !bus.flush;
    assign pop  = (count != 2'd0) && bus.out_ready && !bus.flush;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]     <= RESET_ENTRY;
            mem[1]     <= RESET_ENTRY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else if (bus.flush) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count      <= count_next;
            in_ready_q <= (count_next != 2'd2);
        end
    end

    entry_t head;
    assign head = mem[rd_ptr];

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = (count != 2'd0);
    assign bus.out_a          = head.a;
    assign bus.out_b          = head.b;
    assign bus.out_instr_type = head.instr_type;
    assign bus.out_opcode_e   = head.opcode_e;
    assign bus.out_imm        = head.imm;
    assign bus.out_store_data = head.store_data;
    assign bus.out_pc         = head.pc;
    assign bus.out_rd         = head.rd;
    assign bus.out_illegal    = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed + randomized bench for alu_issue_stage.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. Expected entries come from a table-driven RV32I model.
module tb_alu_issue_stage;
    import rv32i_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0]         a;
        logic [W-1:0]         b;
        logic [W-1:0]         imm;
        logic [W-1:0]         sd;
        logic [W-1:0]         pc;
        logic [4:0]           rd;
        rv32i_base_instr_type ty;
        rv32i_base_instr      op;
        logic                 ill;
    } exp_t;

    localparam int EW = $bits(exp_t);

    typedef struct {
        logic [6:0]           opc;
        int                   f3;   // -1: any
        int                   f7;   // -1: any
        rv32i_base_instr_type ty;
        rv32i_base_instr      op;
    } rule_t;

    // ---------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_WIDTH(W)) bus();
    alu_issue_stage #(.DATA_WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad = 0;
    int n_out = 0;
    logic rand_ready = 1'b0;
    logic [EW-1:0] exp_q[$];

    // --------------------------------------------------------------- model
    rule_t rules [37] = '{
        '{7'h37, -1, -1, U_TYPE, LUI},  '{7'h17, -1, -1, U_TYPE, AUIPC},
        '{7'h6F, -1, -1, J_TYPE, JAL},  '{7'h67,  0, -1, I_TYPE, JALR},
        '{7'h63, 0, -1, B_TYPE, BEQ},   '{7'h63, 1, -1, B_TYPE, BNE},
        '{7'h63, 4, -1, B_TYPE, BLT},   '{7'h63, 5, -1, B_TYPE, BGE},
        '{7'h63, 6, -1, B_TYPE, BLTU},  '{7'h63, 7, -1, B_TYPE, BGEU},
        '{7'h03, 0, -1, I_TYPE, LB},    '{7'h03, 1, -1, I_TYPE, LH},
        '{7'h03, 2, -1, I_TYPE, LW},    '{7'h03, 4, -1, I_TYPE, LBU},
        '{7'h03, 5, -1, I_TYPE, LHU},
        '{7'h23, 0, -1, S_TYPE, SB},    '{7'h23, 1, -1, S_TYPE, SH},
        '{7'h23, 2, -1, S_TYPE, SW},
        '{7'h13, 0, -1, I_TYPE, ADDI},  '{7'h13, 2, -1, I_TYPE, SLTI},
        '{7'h13, 3, -1, I_TYPE, SLTIU}, '{7'h13, 4, -1, I_TYPE, XORI},
        '{7'h13, 6, -1, I_TYPE, ORI},   '{7'h13, 7, -1, I_TYPE, ANDI},
        '{7'h13, 1, 0, I_TYPE, SLLI},   '{7'h13, 5, 0, I_TYPE, SRLI},
        '{7'h13, 5, 32, I_TYPE, SRAI},
        '{7'h33, 0, 0, R_TYPE, ADD},    '{7'h33, 0, 32, R_TYPE, SUB},
        '{7'h33, 1, 0, R_TYPE, SLL},    '{7'h33, 2, 0, R_TYPE, SLT},
        '{7'h33, 3, 0, R_TYPE, SLTU},   '{7'h33, 4, 0, R_TYPE, XOR},
        '{7'h33, 5, 0, R_TYPE, SRL},    '{7'h33, 5, 32, R_TYPE, SRA},
        '{7'h33, 6, 0, R_TYPE, OR},     '{7'h33, 7, 0, R_TYPE, AND}
    };

    function automatic exp_t model(input logic [31:0] ins, input logic [W-1:0] pc,
                                   input logic [W-1:0] rs1, input logic [W-1:0] rs2);
        exp_t e;
        int hit;
        logic signed [31:0] ii;
        int bi, ji;
        hit = -1;
        for (int i = 0; i < 37; i++) begin
            if (ins[6:0] == rules[i].opc &&
                (rules[i].f3 < 0 || rules[i].f3 == int'(ins[14:12])) &&
                (rules[i].f7 < 0 || rules[i].f7 == int'(ins[31:25])))
                hit = i;
        end
        e = '0;
        e.sd = rs2;
        e.pc = pc;
        e.ty = I_TYPE;
        e.op = ADDI;
        if (hit < 0) begin
            e.ill = 1'b1;
            return e;
        end
        e.ty = rules[hit].ty;
        e.op = rules[hit].op;
        e.rd = ins[11:7];
        ii = $signed(ins) >>> 20;
        bi = (ins[31] ? -4096 : 0) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5)
             + (int'(ins[11:8]) << 1);
        ji = (ins[31] ? -(1 << 20) : 0) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11)
             + (int'(ins[30:21]) << 1);
        case (e.ty)
            R_TYPE: begin e.a = rs1; e.b = rs2; end
            I_TYPE: begin
                e.a = rs1;
                e.imm = ii;
                if (e.op == SLLI || e.op == SRLI || e.op == SRAI) e.b = W'(ins[24:20]);
                else e.b = ii;
            end
            S_TYPE: begin
                e.imm = (ii & 32'hFFFF_FFE0) | 32'(ins[11:7]);
                e.a = rs1; e.b = e.imm; e.rd = '0;
            end
            B_TYPE: begin e.imm = bi; e.a = rs1; e.b = rs2; e.rd = '0; end
            U_TYPE: begin
                e.imm = ins & 32'hFFFF_F000;
                e.a = (e.op == LUI) ? '0 : pc;
                e.b = e.imm;
            end
            default: begin e.imm = ji; e.a = pc; e.b = e.imm; end
        endcase
        return e;
    endfunction

    function automatic exp_t cur_pack();
        exp_t e;
        e.a = bus.out_a; e.b = bus.out_b; e.imm = bus.out_imm;
        e.sd = bus.out_store_data; e.pc = bus.out_pc; e.rd = bus.out_rd;
        e.ty = bus.out_instr_type; e.op = bus.out_opcode_e; e.ill = bus.out_illegal;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.ty = I_TYPE;
        e.op = ADDI;
        return e;
    endfunction

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic check_reset(input string name);
        check({name, "_valid"}, bus.out_valid, 1'b0);
        check({name, "_ready"}, bus.in_ready, 1'b1);
        check({name, "_data"}, cur_pack(), reset_exp());
    endtask

    // -------------------------------------------------------------- drivers
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [W-1:0] pc,
                        input logic [W-1:0] rs1, input logic [W-1:0] rs2);
        logic ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc = pc;
        bus.in_rs1_val = rs1;
        bus.in_rs2_val = rs2;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back(model(ins, pc, rs1, rs2));
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!ok) fail_now("accept_timeout");
        else begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [31:0] ins;
        logic [6:0] opcs [9];
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        ins = $urandom;
        if ($urandom_range(0, 9) < 8) ins[6:0] = opcs[$urandom_range(0, 8)];
        if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        send(ins, $urandom & 32'hFFFF_FFFC, $urandom, $urandom);
    endtask

    // One flush cycle, optionally with a (dropped) input presented alongside.
    task automatic flush_cycle(input logic with_input);
        bus.flush = 1'b1;
        if (with_input) begin
            bus.in_valid = 1'b1;
            bus.in_instr = $urandom;
            bus.in_pc = $urandom;
        end
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) fail_now({name, "_drain"});
        @(negedge clk);
        check({name, "_idle_valid"}, bus.out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------------------------------------------- scoreboard monitor
    logic held = 1'b0;
    exp_t held_val;

    initial begin
        exp_t cur;
        forever begin
            @(negedge clk);
            cur = cur_pack();
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held && bus.out_valid) check("hold_stable", cur, held_val);
                if (bus.out_valid && bus.out_ready && !bus.flush) begin
                    if (exp_q.size() == 0) fail_now("unexpected_output");
                    else check($sformatf("entry%0d", n_out), cur, exp_q.pop_front());
                    n_out++;
                end
                held = bus.out_valid && !bus.out_ready && !bus.flush;
                held_val = cur;
            end
        end
    end

    // ----------------------------------------------------------------- main
    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.in_pc = '0;
        bus.in_rs1_val = '0;
        bus.in_rs2_val = '0;
        bus.out_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2 check_reset("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // ADDI x1,x0,5: one-cycle latency from an empty buffer
        send(32'h0050_0093, 32'h0, 32'h0, 32'h7);
        @(negedge clk);
        check("t1_valid", bus.out_valid, 1'b1);
        check("t1_a", bus.out_a, 32'd0);
        check("t1_b", bus.out_b, 32'd5);
        check("t1_rd", bus.out_rd, 5'd1);
        check("t1_type", bus.out_instr_type, I_TYPE);
        check("t1_op", bus.out_opcode_e, ADDI);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;

        send(32'h4020_81B3, 32'h4, 32'd10, 32'd3);          // SUB
        send(32'h4033_5293, 32'h8, 32'h8000_0000, 32'h0);   // SRAI
        send(32'hC033_5293, 32'hC, 32'h8000_0000, 32'h0);   // shift, funct7=0x60
        send(32'h1234_5097, 32'h100, 32'h55, 32'h66);       // AUIPC
        send(32'h0020_8463, 32'h104, 32'd9, 32'd9);         // BEQ
        send(32'hFFFF_FFFF, 32'h108, 32'h1234, 32'h5678);   // illegal
        wait_drain("directed");

        // Backpressure: third back-to-back word must stall
        bus.out_ready = 1'b0;
        send(32'h0010_0113, 32'h200, 32'h1, 32'h2);
        send(32'h0020_0193, 32'h204, 32'h3, 32'h4);
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h0030_0213;
        bus.in_pc = 32'h208;
        bus.in_rs1_val = 32'h5;
        bus.in_rs2_val = 32'h6;
        @(negedge clk);
        check("bp_full_ready", bus.in_ready, 1'b0);
        check("bp_full_valid", bus.out_valid, 1'b1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_still_full", bus.in_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("bp_recover", bus.in_ready, 1'b1);
        exp_q.push_back(model(32'h0030_0213, 32'h208, 32'h5, 32'h6));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_drain("bp");

        // Flush with two entries held
        bus.out_ready = 1'b0;
        send(32'h0000_0033, 32'h300, 32'h1, 32'h1);
        send(32'h0000_0037, 32'h304, 32'h1, 32'h1);
        flush_cycle(1'b1);
        @(negedge clk);
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_ready", bus.in_ready, 1'b1);
        @(posedge clk); #1;

        // Flush beats out_ready and drops a concurrently accepted input
        bus.out_ready = 1'b1;
        send(32'h0000_A003, 32'h400, 32'h40, 32'h0);
        flush_cycle(1'b1);
        @(negedge clk);
        check("flush2_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check("flush2_dropped", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a busy buffer
        bus.out_ready = 1'b0;
        send(32'h0010_0093, 32'h500, 32'h1, 32'h2);
        send(32'h0020_0093, 32'h504, 32'h1, 32'h2);
        #2 rst_n = 1'b0;
        #1 check_reset("mid_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_valid", bus.out_valid, 1'b0);
        @(posedge clk); #1;

        // Random traffic with random backpressure and occasional flushes
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) flush_cycle($urandom_range(0, 1) == 1);
            else send_rand();
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        wait_drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
